// File: rtl/monster_pool.sv
// monster_pool: fixed-size pool of Doodle Jump monsters with spawn, bounce/scroll motion,
// retirement and a per-pixel hit test. Define MONSTER_BOB_EN to add a vertical bob.
module monster_pool #(
  parameter int NUM_MONS = 4,
  parameter int X_MIN    = 160,
  parameter int X_MAX    = 479,
  parameter int SIZE_X   = 20,
  parameter int SIZE_Y   = 11,
  parameter int SPAWN_Y  = 40,
  parameter int Y_OFF    = 479,
  parameter int SPEED_X  = 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   gene,
  input  logic [NUM_MONS-1:0]    kill_mask,
  input  logic [19:0]            random_num,
  input  logic [9:0]             distance,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic [NUM_MONS*10-1:0] monster_x_flat,
  output logic [NUM_MONS*10-1:0] monster_y_flat,
  output logic [NUM_MONS-1:0]    active,
  output logic [3:0]             mons_count,
  output logic                   spawn_fail,
  output logic                   is_monster,
  output logic [2:0]             monster_id
);
  localparam logic [10:0]        X_LO    = 11'(X_MIN + SIZE_X);
  localparam logic [10:0]        X_HI    = 11'(X_MAX - SIZE_X);
  localparam logic [10:0]        X_SPD   = 11'(SPEED_X);
  localparam logic [9:0]         Y_SPAWN = 10'(SPAWN_Y);
  localparam logic signed [11:0] Y_LIM   = 12'(Y_OFF);
  localparam logic signed [11:0] HALF_X  = 12'(SIZE_X);
  localparam logic signed [11:0] HALF_Y  = 12'(SIZE_Y);

  logic                frame_prev_q, gene_prev_q, frame_edge_q, gene_edge_q;
  logic [9:0]          x_q [NUM_MONS];
  logic [9:0]          x_d [NUM_MONS];
  logic [9:0]          y_q [NUM_MONS];
  logic [9:0]          y_d [NUM_MONS];
  logic [NUM_MONS-1:0] dir_q, dir_d;  // 1 = moving right
  logic [NUM_MONS-1:0] active_q, active_d;
  logic [3:0]          count_q, count_d;
  logic                spawn_fail_q, spawn_fail_d;
  logic [NUM_MONS-1:0] eligible, spawn_sel, hit;
  logic                found;
  logic [10:0]         x_step [NUM_MONS];
  logic signed [11:0]  y_step [NUM_MONS];
  logic signed [11:0]  bob;
  logic                unused_rand;

  assign unused_rand = ^random_num[19:8];

`ifdef MONSTER_BOB_EN
  logic [4:0] frame_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)          frame_cnt_q <= '0;
    else if (frame_edge_q) frame_cnt_q <= frame_cnt_q + 5'd1;
  end

  always_comb begin
    case (frame_cnt_q[4:2])
      3'd0:       bob = 12'sd2;
      3'd1, 3'd7: bob = 12'sd1;
      3'd3, 3'd5: bob = -12'sd1;
      3'd4:       bob = -12'sd2;
      default:    bob = 12'sd0;
    endcase
  end
`else
  assign bob = 12'sd0;
`endif

  // One spare bit over 11 keeps a large scroll from wrapping negative.
  for (genvar gi = 0; gi < NUM_MONS; gi++) begin : g_slot
    assign x_step[gi] = dir_q[gi] ? ({1'b0, x_q[gi]} + X_SPD) : ({1'b0, x_q[gi]} - X_SPD);
    assign y_step[gi] = $signed({2'b00, y_q[gi]}) + $signed({2'b00, distance}) + bob;
    assign hit[gi] = active_q[gi]
        && ($signed({2'b00, DrawX}) >= ($signed({2'b00, x_q[gi]}) - HALF_X))
        && ($signed({2'b00, DrawX}) <= ($signed({2'b00, x_q[gi]}) + HALF_X))
        && ($signed({2'b00, DrawY}) >= ($signed({2'b00, y_q[gi]}) - HALF_Y))
        && ($signed({2'b00, DrawY}) <= ($signed({2'b00, y_q[gi]}) + HALF_Y));
    assign monster_x_flat[10*gi +: 10] = x_q[gi];
    assign monster_y_flat[10*gi +: 10] = y_q[gi];
  end

  // Slots being killed this cycle are skipped when picking the spawn target.
  always_comb begin
    eligible  = ~active_q & ~kill_mask;
    spawn_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_MONS; i++) begin
      if (eligible[i] && !found) begin
        spawn_sel[i] = gene_edge_q;
        found        = 1'b1;
      end
    end
    spawn_fail_d = gene_edge_q && !found;
  end

  always_comb begin
    for (int i = 0; i < NUM_MONS; i++) begin
      x_d[i]      = x_q[i];
      y_d[i]      = y_q[i];
      dir_d[i]    = dir_q[i];
      active_d[i] = active_q[i];
      if (kill_mask[i]) begin
        active_d[i] = 1'b0;
      end else if (frame_edge_q && active_q[i] && (y_step[i] > Y_LIM)) begin
        active_d[i] = 1'b0;
      end else if (spawn_sel[i]) begin
        x_d[i]      = 10'(X_LO + {3'b000, random_num[7:0]});
        y_d[i]      = Y_SPAWN;
        dir_d[i]    = 1'b1;
        active_d[i] = 1'b1;
      end else if (frame_edge_q && active_q[i]) begin
        y_d[i] = y_step[i][11] ? 10'd0 : y_step[i][9:0];
        if (x_step[i] >= X_HI) begin
          x_d[i]   = X_HI[9:0];
          dir_d[i] = 1'b0;
        end else if (x_step[i] <= X_LO) begin
          x_d[i]   = X_LO[9:0];
          dir_d[i] = 1'b1;
        end else begin
          x_d[i] = x_step[i][9:0];
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_MONS; i++) count_d = count_d + {3'b000, active_d[i]};
  end

  always_comb begin
    monster_id = 3'd0;
    for (int i = NUM_MONS - 1; i >= 0; i--) begin
      if (hit[i]) monster_id = 3'(i);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_prev_q <= 1'b0;
      gene_prev_q  <= 1'b0;
      frame_edge_q <= 1'b0;
      gene_edge_q  <= 1'b0;
      for (int i = 0; i < NUM_MONS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      dir_q        <= '0;
      active_q     <= '0;
      count_q      <= '0;
      spawn_fail_q <= 1'b0;
    end else begin
      frame_prev_q <= frame_clk;
      gene_prev_q  <= gene;
      frame_edge_q <= frame_clk & ~frame_prev_q;
      gene_edge_q  <= gene & ~gene_prev_q;
      for (int i = 0; i < NUM_MONS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      dir_q        <= dir_d;
      active_q     <= active_d;
      count_q      <= count_d;
      spawn_fail_q <= spawn_fail_d;
    end
  end

  assign active     = active_q;
  assign mons_count = count_q;
  assign spawn_fail = spawn_fail_q;
  assign is_monster = |hit;

endmodule

// File: tb/tb_monster_pool.sv
// Testbench for monster_pool: scenario tasks with a queue-based spawn scoreboard.
module tb_monster_pool;
  localparam int N = 4;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            frame_clk = 1'b0;
  logic            gene = 1'b0;
  logic [N-1:0]    kill_mask = '0;
  logic [19:0]     random_num = '0;
  logic [9:0]      distance = '0;
  logic [9:0]      DrawX = '0;
  logic [9:0]      DrawY = '0;
  logic [N*10-1:0] monster_x_flat, monster_y_flat;
  logic [N-1:0]    active;
  logic [3:0]      mons_count;
  logic            spawn_fail, is_monster;
  logic [2:0]      monster_id;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int           slot;
    logic [9:0]   x;
    logic [9:0]   y;
    logic [N-1:0] act;
    logic [3:0]   cnt;
  } spawn_exp_t;
  spawn_exp_t sb[$];

  always #5 Clk = ~Clk;

  monster_pool #(.NUM_MONS(N)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .gene(gene),
    .kill_mask(kill_mask), .random_num(random_num), .distance(distance),
    .DrawX(DrawX), .DrawY(DrawY), .monster_x_flat(monster_x_flat),
    .monster_y_flat(monster_y_flat), .active(active), .mons_count(mons_count),
    .spawn_fail(spawn_fail), .is_monster(is_monster), .monster_id(monster_id)
  );

  function automatic logic [9:0] mx(int i);
    return monster_x_flat[10*i +: 10];
  endfunction

  function automatic logic [9:0] my(int i);
    return monster_y_flat[10*i +: 10];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_gene(input logic [7:0] r);
    random_num = {12'h000, r};
    gene = 1'b1;
    tick();
    gene = 1'b0;
    tick();
    $display("gene rand=%02h -> active=%b count=%0d spawn_fail=%b", r, active, mons_count, spawn_fail);
  endtask

  task automatic pulse_frame();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  task automatic hard_reset();
    Reset_n = 1'b0; gene = 1'b0; frame_clk = 1'b0; kill_mask = '0; distance = '0;
    tick();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick(); tick();
    n_checks++; if (active !== 4'b0000) begin n_fail++; $display("FAIL reset_active got=%b exp=0000", active); end
    n_checks++; if (mons_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", mons_count); end
    n_checks++; if (spawn_fail !== 1'b0) begin n_fail++; $display("FAIL reset_spawn_fail got=%b exp=0", spawn_fail); end
    n_checks++; if (is_monster !== 1'b0) begin n_fail++; $display("FAIL reset_is_monster got=%b exp=0", is_monster); end
    n_checks++; if ({monster_x_flat, monster_y_flat} !== '0) begin n_fail++; $display("FAIL reset_xy got=%h exp=0", {monster_x_flat, monster_y_flat}); end
    Reset_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_spawn();
    spawn_exp_t e;
    e = '{slot: 0, x: 10'd196, y: 10'd40, act: 4'b0001, cnt: 4'd1};
    sb.push_back(e);
    pulse_gene(8'h10);
    e = sb.pop_front();
    n_checks++; if (mx(e.slot) !== e.x) begin n_fail++; $display("FAIL spawn_x got=%0d exp=%0d", mx(e.slot), e.x); end
    n_checks++; if (my(e.slot) !== e.y) begin n_fail++; $display("FAIL spawn_y got=%0d exp=%0d", my(e.slot), e.y); end
    n_checks++; if (active !== e.act) begin n_fail++; $display("FAIL spawn_active got=%b exp=%b", active, e.act); end
    n_checks++; if (mons_count !== e.cnt) begin n_fail++; $display("FAIL spawn_count got=%0d exp=%0d", mons_count, e.cnt); end
  endtask

  task automatic test_fill();
    spawn_exp_t e;
    logic [7:0] rv [3];
    rv = '{8'h00, 8'hFF, 8'h55};
    for (int k = 0; k < 3; k++) begin
      e.slot = k + 1;
      e.x    = 10'(180 + int'(rv[k]));
      e.y    = 10'd40;
      e.act  = 4'((1 << (k + 2)) - 1);
      e.cnt  = 4'(k + 2);
      sb.push_back(e);
      pulse_gene(rv[k]);
      e = sb.pop_front();
      n_checks++; if (mx(e.slot) !== e.x) begin n_fail++; $display("FAIL fill_x slot%0d got=%0d exp=%0d", e.slot, mx(e.slot), e.x); end
      n_checks++; if (my(e.slot) !== e.y) begin n_fail++; $display("FAIL fill_y slot%0d got=%0d exp=%0d", e.slot, my(e.slot), e.y); end
      n_checks++; if (active !== e.act) begin n_fail++; $display("FAIL fill_active got=%b exp=%b", active, e.act); end
      n_checks++; if (mons_count !== e.cnt) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", mons_count, e.cnt); end
      n_checks++; if (spawn_fail !== 1'b0) begin n_fail++; $display("FAIL fill_no_fail got=%b exp=0", spawn_fail); end
    end
    pulse_gene(8'h22);
    n_checks++; if (spawn_fail !== 1'b1) begin n_fail++; $display("FAIL full_spawn_fail got=%b exp=1", spawn_fail); end
    n_checks++; if (active !== 4'b1111) begin n_fail++; $display("FAIL full_active got=%b exp=1111", active); end
    n_checks++; if (mons_count !== 4'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", mons_count); end
    tick();
    n_checks++; if (spawn_fail !== 1'b0) begin n_fail++; $display("FAIL full_pulse_width got=%b exp=0", spawn_fail); end
  endtask

  task automatic test_reset_mid();
    kill_mask = 4'b1000;
    tick();
    kill_mask = 4'b0000;
    $display("kill slot3 -> active=%b count=%0d", active, mons_count);
    n_checks++; if (active !== 4'b0111) begin n_fail++; $display("FAIL kill3_active got=%b exp=0111", active); end
    n_checks++; if (mons_count !== 4'd3) begin n_fail++; $display("FAIL kill3_count got=%0d exp=3", mons_count); end
    DrawX = 10'd196; DrawY = 10'd40;
    #1;
    n_checks++; if (is_monster !== 1'b1) begin n_fail++; $display("FAIL pre_reset_hit got=%b exp=1", is_monster); end
    n_checks++; if (monster_id !== 3'd0) begin n_fail++; $display("FAIL pre_reset_id got=%0d exp=0", monster_id); end
    #1 Reset_n = 1'b0;
    #1;
    $display("async reset -> active=%b count=%0d is_monster=%b", active, mons_count, is_monster);
    n_checks++; if (active !== 4'b0000) begin n_fail++; $display("FAIL async_reset_active got=%b exp=0000", active); end
    n_checks++; if (mons_count !== 4'd0) begin n_fail++; $display("FAIL async_reset_count got=%0d exp=0", mons_count); end
    n_checks++; if (is_monster !== 1'b0) begin n_fail++; $display("FAIL async_reset_hit got=%b exp=0", is_monster); end
    tick();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_bounce();
    hard_reset();
    pulse_gene(8'hFF);
    for (int k = 0; k < 23; k++) pulse_frame();
    n_checks++; if (mx(0) !== 10'd458) begin n_fail++; $display("FAIL bounce_pre got=%0d exp=458", mx(0)); end
    pulse_frame();
    $display("frame -> slot0 x=%0d", mx(0));
    n_checks++; if (mx(0) !== 10'd459) begin n_fail++; $display("FAIL bounce_right_clamp got=%0d exp=459", mx(0)); end
    pulse_frame();
    $display("frame -> slot0 x=%0d", mx(0));
    n_checks++; if (mx(0) !== 10'd458) begin n_fail++; $display("FAIL bounce_turn_left got=%0d exp=458", mx(0)); end
    for (int k = 0; k < 277; k++) pulse_frame();
    n_checks++; if (mx(0) !== 10'd181) begin n_fail++; $display("FAIL bounce_left_pre got=%0d exp=181", mx(0)); end
    pulse_frame();
    $display("frame -> slot0 x=%0d", mx(0));
    n_checks++; if (mx(0) !== 10'd180) begin n_fail++; $display("FAIL bounce_left_clamp got=%0d exp=180", mx(0)); end
    pulse_frame();
    $display("frame -> slot0 x=%0d", mx(0));
    n_checks++; if (mx(0) !== 10'd181) begin n_fail++; $display("FAIL bounce_turn_right got=%0d exp=181", mx(0)); end
    n_checks++; if (my(0) !== 10'd40) begin n_fail++; $display("FAIL bounce_y_still got=%0d exp=40", my(0)); end
  endtask

  task automatic test_retire();
    hard_reset();
    pulse_gene(8'h10);
    distance = 10'd430;
    pulse_frame();
    $display("frame dist=430 -> y=%0d active=%b", my(0), active);
    n_checks++; if (my(0) !== 10'd470) begin n_fail++; $display("FAIL scroll_y got=%0d exp=470", my(0)); end
    distance = 10'd15;
    pulse_frame();
    $display("frame dist=15 -> active=%b count=%0d", active, mons_count);
    n_checks++; if (active !== 4'b0000) begin n_fail++; $display("FAIL retire_active got=%b exp=0000", active); end
    n_checks++; if (mons_count !== 4'd0) begin n_fail++; $display("FAIL retire_count got=%0d exp=0", mons_count); end
    distance = 10'd0;
    pulse_gene(8'h10);
    distance = 10'd439;
    pulse_frame();
    n_checks++; if ({active[0], my(0)} !== {1'b1, 10'd479}) begin n_fail++; $display("FAIL edge_y479 got=%b/%0d exp=1/479", active[0], my(0)); end
    distance = 10'd1;
    pulse_frame();
    n_checks++; if (active !== 4'b0000) begin n_fail++; $display("FAIL retire_480 got=%b exp=0000", active); end
    distance = 10'd0;
    pulse_gene(8'h10);
    pulse_gene(8'h20);
    random_num = 20'h00030;
    gene = 1'b1;
    tick();
    gene = 1'b0; kill_mask = 4'b0010;
    tick();
    kill_mask = 4'b0000;
    $display("kill slot1 + gene -> active=%b count=%0d", active, mons_count);
    n_checks++; if (active !== 4'b0101) begin n_fail++; $display("FAIL kill_spawn_active got=%b exp=0101", active); end
    n_checks++; if (mons_count !== 4'd2) begin n_fail++; $display("FAIL kill_spawn_count got=%0d exp=2", mons_count); end
    n_checks++; if ({mx(2), my(2)} !== {10'd228, 10'd40}) begin n_fail++; $display("FAIL kill_spawn_xy got=%0d,%0d exp=228,40", mx(2), my(2)); end
    random_num = 20'h00040;
    gene = 1'b1;
    tick();
    gene = 1'b0; kill_mask = 4'b0010;
    tick();
    kill_mask = 4'b0000;
    $display("kill free slot1 + gene -> active=%b count=%0d", active, mons_count);
    n_checks++; if (active !== 4'b1101) begin n_fail++; $display("FAIL kill_free_active got=%b exp=1101", active); end
    n_checks++; if (mx(3) !== 10'd244) begin n_fail++; $display("FAIL kill_free_x got=%0d exp=244", mx(3)); end
  endtask

  task automatic test_pixel();
    hard_reset();
    pulse_gene(8'h00);
    pulse_gene(8'h77);
    distance = 10'd160;
    pulse_frame();
    distance = 10'd0;
    n_checks++; if ({mx(1), my(1)} !== {10'd300, 10'd200}) begin n_fail++; $display("FAIL pix_setup got=%0d,%0d exp=300,200", mx(1), my(1)); end
    DrawX = 10'd280; DrawY = 10'd189; #1;
    n_checks++; if ({is_monster, monster_id} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL pix_corner_in got=%b/%0d exp=1/1", is_monster, monster_id); end
    DrawX = 10'd279; #1;
    n_checks++; if (is_monster !== 1'b0) begin n_fail++; $display("FAIL pix_left_out got=%b exp=0", is_monster); end
    DrawX = 10'd320; DrawY = 10'd211; #1;
    n_checks++; if ({is_monster, monster_id} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL pix_far_corner got=%b/%0d exp=1/1", is_monster, monster_id); end
    DrawX = 10'd321; #1;
    n_checks++; if (is_monster !== 1'b0) begin n_fail++; $display("FAIL pix_right_out got=%b exp=0", is_monster); end
    DrawX = 10'd300; DrawY = 10'd212; #1;
    n_checks++; if (is_monster !== 1'b0) begin n_fail++; $display("FAIL pix_bottom_out got=%b exp=0", is_monster); end
    DrawX = 10'd190; DrawY = 10'd200; #1;
    n_checks++; if ({is_monster, monster_id} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL pix_slot0 got=%b/%0d exp=1/0", is_monster, monster_id); end
    $display("pixel tests done");
  endtask

  task automatic test_back_to_back();
    random_num = 20'h00010;
    gene = 1'b1; frame_clk = 1'b1;
    tick();
    gene = 1'b0; frame_clk = 1'b0;
    tick();
    $display("gene+frame -> active=%b x0=%0d x1=%0d x2=%0d", active, mx(0), mx(1), mx(2));
    n_checks++; if ({mx(2), my(2)} !== {10'd196, 10'd40}) begin n_fail++; $display("FAIL b2b_spawn_xy got=%0d,%0d exp=196,40", mx(2), my(2)); end
    n_checks++; if ({mx(0), mx(1)} !== {10'd182, 10'd301}) begin n_fail++; $display("FAIL b2b_move got=%0d,%0d exp=182,301", mx(0), mx(1)); end
    n_checks++; if (mons_count !== 4'd3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", mons_count); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_fill();
    test_reset_mid();
    test_bounce();
    test_retire();
    test_pixel();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
